// File: rtl/cache_ro.sv
// -----------------------------------------------------------------------------
// cache_ro -- set-associative look-aside data cache, registered lookup.
//
// A producer fills lines with write requests and a consumer reads them back.
// A read returns either the cached word (hit) or a miss indication. Misses are
// only reported; there is no backing-store port. One request per cycle.
//
// Request handshake: a request is offered by holding en=1 across a rising edge.
// There is no ready signal; the cache takes every request it is offered.
// The response (o_data/o_success) is registered at that same edge and held
// until the next edge. An edge with en=0 produces a zero response.
//
// Ports:
//   clk        single clock, rising-edge
//   rst        asynchronous active-low reset (clears valid bits, victim
//              pointers and outputs; tag/data storage is not cleared)
//   en         request valid this cycle
//   wrt        1 = write/fill, 0 = read (sampled only with en=1)
//   i_addr     block address [BIT_TOTAL-1:0]; index = low BIT_INDEX bits,
//              tag = remaining upper bits
//   i_data     write data (ignored on reads)
//   o_data     read-hit data, otherwise 0 (registered)
//   o_success  read hit or write accepted (registered)
//
// Optional build macro CACHE_RO_STATS_EN adds:
//   o_hit_cnt  saturating count of read hits
//   o_miss_cnt saturating count of read misses
// -----------------------------------------------------------------------------
module cache_ro #(
    parameter int SIZE_BLOCK = 32,
    parameter int BIT_TOTAL  = 24,
    parameter int BIT_INDEX  = 5,
    parameter int WAY        = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  wrt,
    input  logic [BIT_TOTAL-1:0]  i_addr,
    input  logic [SIZE_BLOCK-1:0] i_data,
    output logic [SIZE_BLOCK-1:0] o_data,
    output logic                  o_success
`ifdef CACHE_RO_STATS_EN
    ,
    output logic [31:0]           o_hit_cnt,
    output logic [31:0]           o_miss_cnt
`endif
);

    localparam int SETS  = 1 << BIT_INDEX;
    localparam int TAG_W = BIT_TOTAL - BIT_INDEX;
    localparam int PTR_W = (WAY > 1) ? $clog2(WAY) : 1;

    // Storage: valid bits and victim pointers are reset, tag/data are not.
    logic [WAY-1:0]        valid_q  [SETS];
    logic [PTR_W-1:0]      victim_q [SETS];
    logic [TAG_W-1:0]      tag_q    [SETS][WAY];
    logic [SIZE_BLOCK-1:0] data_q   [SETS][WAY];

    logic [BIT_INDEX-1:0]  idx;
    logic [TAG_W-1:0]      tag;

    logic                  hit;
    logic [PTR_W-1:0]      hit_way;
    logic [SIZE_BLOCK-1:0] hit_data;
    logic                  inv_found;
    logic [PTR_W-1:0]      inv_way;
    logic [PTR_W-1:0]      fill_way;
    logic                  need_evict;
    logic [PTR_W-1:0]      victim_next;

    assign idx = i_addr[BIT_INDEX-1:0];
    assign tag = i_addr[BIT_TOTAL-1:BIT_INDEX];

    // Lookup: scanning from way 0 upward and latching the first match makes
    // the lowest-numbered way win if a duplicate tag ever exists in a set.
    // The same scan finds the lowest invalid way for fills.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        hit_data  = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < WAY; w++) begin
            if (!hit && valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
                hit      = 1'b1;
                hit_way  = PTR_W'(w);
                hit_data = data_q[idx][w];
            end
            if (!inv_found && !valid_q[idx][w]) begin
                inv_found = 1'b1;
                inv_way   = PTR_W'(w);
            end
        end
    end

    // Write target: in-place on a tag hit, else first free way, else the
    // round-robin victim. Only the last case advances the victim pointer.
    always_comb begin
        need_evict  = !hit && !inv_found;
        fill_way    = victim_q[idx];
        if (hit) begin
            fill_way = hit_way;
        end else if (inv_found) begin
            fill_way = inv_way;
        end
        victim_next = (victim_q[idx] == PTR_W'(WAY - 1)) ? '0
                                                          : victim_q[idx] + 1'b1;
    end

    // Control state and registered response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s]  <= '0;
                victim_q[s] <= '0;
            end
            o_data    <= '0;
            o_success <= 1'b0;
        end else begin
            o_data    <= '0;
            o_success <= 1'b0;
            if (en) begin
                if (wrt) begin
                    o_success               <= 1'b1;
                    valid_q[idx][fill_way]  <= 1'b1;
                    if (need_evict) begin
                        victim_q[idx] <= victim_next;
                    end
                end else if (hit) begin
                    o_success <= 1'b1;
                    o_data    <= hit_data;
                end
            end
        end
    end

    // Tag/data arrays carry no reset; a stale entry is harmless because its
    // valid bit is cleared. Writes are suppressed while reset is held.
    always_ff @(posedge clk) begin
        if (rst && en && wrt) begin
            tag_q[idx][fill_way]  <= tag;
            data_q[idx][fill_way] <= i_data;
        end
    end

`ifdef CACHE_RO_STATS_EN
    // Read statistics; writes are not counted. Both counters stick at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_hit_cnt  <= '0;
            o_miss_cnt <= '0;
        end else if (en && !wrt) begin
            if (hit) begin
                if (o_hit_cnt != '1) o_hit_cnt <= o_hit_cnt + 32'd1;
            end else begin
                if (o_miss_cnt != '1) o_miss_cnt <= o_miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_ro.sv
// -----------------------------------------------------------------------------
// tb_cache_ro -- self-checking bench for cache_ro (default parameters:
// 32-bit blocks, 24-bit address, 32 sets, 2 ways).
// Each request pushes its expected {o_success, o_data} onto exp_q when driven;
// the entry is popped and compared one clock later when the response appears.
// -----------------------------------------------------------------------------
module tb_cache_ro;

  localparam int DW = 32;
  localparam int AW = 24;

  // ---------------------------------------------------------------- clk/reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          en = 1'b0;
  logic          wrt = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [DW-1:0] i_data = '0;
  logic [DW-1:0] o_data;
  logic          o_success;
`ifdef CACHE_RO_STATS_EN
  logic [31:0]   o_hit_cnt;
  logic [31:0]   o_miss_cnt;
  int            exp_hits = 0;
  int            exp_misses = 0;
`endif

  cache_ro #(
    .SIZE_BLOCK(DW),
    .BIT_TOTAL (AW),
    .BIT_INDEX (5),
    .WAY       (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .wrt      (wrt),
    .i_addr   (i_addr),
    .i_data   (i_data),
    .o_data   (o_data),
    .o_success(o_success)
`ifdef CACHE_RO_STATS_EN
    ,
    .o_hit_cnt (o_hit_cnt),
    .o_miss_cnt(o_miss_cnt)
`endif
  );

  // --------------------------------------------------------------- scoreboard
  logic [DW:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // --------------------------------------------------------------- drivers
  // Drive on the falling edge, sample 1 ns after the rising edge.
  task automatic req(input string tag, input logic e, input logic w,
                     input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input logic es, input logic [DW-1:0] ed);
    logic [DW:0] exp;
    @(negedge clk);
    en = e; wrt = w; i_addr = a; i_data = d;
    exp_q.push_back({es, ed});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 64'd0, 64'd1);
    end else begin
      exp = exp_q.pop_front();
      check(tag, {31'd0, o_success, o_data}, {31'd0, exp});
    end
  endtask

  task automatic wr(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req(tag, 1'b1, 1'b1, a, d, 1'b1, '0);
  endtask

  task automatic rd_hit(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d);
`ifdef CACHE_RO_STATS_EN
    exp_hits++;
`endif
    req(tag, 1'b1, 1'b0, a, DW'($urandom), 1'b1, d);
  endtask

  task automatic rd_miss(input string tag, input logic [AW-1:0] a);
`ifdef CACHE_RO_STATS_EN
    exp_misses++;
`endif
    req(tag, 1'b1, 1'b0, a, DW'($urandom), 1'b0, '0);
  endtask

  task automatic idle(input string tag);
    req(tag, 1'b0, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom), 1'b0, '0);
  endtask

  // --------------------------------------------------------------- watchdog
  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  // --------------------------------------------------------------- stimulus
  logic [DW-1:0] rv [5];
  logic [DW-1:0] d_ones, d_31;

  initial begin
    for (int i = 0; i < 5; i++) rv[i] = DW'($urandom);
    d_ones = DW'($urandom);
    d_31   = DW'($urandom);

    // Reset state.
    #1;
    check("reset_success", {63'd0, o_success}, 64'd0);
    check("reset_data", {32'd0, o_data}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Cold miss, then basic fills.
    rd_miss("cold_rd3", 24'd3);
    wr("wr3", 24'd3, 32'hA);
    rd_hit("rd3", 24'd3, 32'hA);
    wr("wr4", 24'd4, 32'hB);
    wr("wr5", 24'd5, 32'hC);
    rd_hit("rd4", 24'd4, 32'hB);
    rd_hit("rd5", 24'd5, 32'hC);

    // Set 0 conflict: third fill evicts the first (address 0).
    wr("wr0", 24'd0, 32'hE);
    wr("wr32", 24'd32, 32'h8);
    wr("wr64", 24'd64, 32'h7);
    rd_miss("rd0_evicted", 24'd0);
    rd_hit("rd32", 24'd32, 32'h8);
    rd_hit("rd64", 24'd64, 32'h7);

    // Overwrite in place keeps FIFO order: 3 still oldest, evicted by 67.
    wr("wr3_again", 24'd3, 32'hA);
    wr("wr3_over", 24'd3, 32'h5);
    rd_hit("rd3_over", 24'd3, 32'h5);
    wr("wr35", 24'd35, 32'h23);
    wr("wr67", 24'd67, 32'h43);
    rd_miss("rd3_evicted", 24'd3);
    rd_hit("rd35", 24'd35, 32'h23);
    rd_hit("rd67", 24'd67, 32'h43);

    // Idle cycles: zero response right after a hit, contents untouched.
    rd_hit("rd4_pre_idle", 24'd4, 32'hB);
    for (int i = 0; i < 3; i++) idle("idle");
    rd_hit("rd4_post_idle", 24'd4, 32'hB);

    // Round-robin wrap on set 7: 7,39 fill; 71,103 evict; 135 evicts 71.
    wr("rr_w7", 24'd7, rv[0]);
    wr("rr_w39", 24'd39, rv[1]);
    wr("rr_w71", 24'd71, rv[2]);
    wr("rr_w103", 24'd103, rv[3]);
    rd_miss("rr_rd7", 24'd7);
    rd_miss("rr_rd39", 24'd39);
    rd_hit("rr_rd71", 24'd71, rv[2]);
    rd_hit("rr_rd103", 24'd103, rv[3]);
    wr("rr_w135", 24'd135, rv[4]);
    rd_miss("rr_rd71_gone", 24'd71);
    rd_hit("rr_rd103_kept", 24'd103, rv[3]);
    rd_hit("rr_rd135", 24'd135, rv[4]);

    // Boundary addresses: all-ones and same-index/different-tag neighbour.
    wr("wr_ones", 24'hFF_FFFF, d_ones);
    wr("wr_31", 24'd31, d_31);
    rd_hit("rd_ones", 24'hFF_FFFF, d_ones);
    rd_hit("rd_31", 24'd31, d_31);
    rd_miss("rd_ones_alias", 24'h7F_FFFF);

    // Asynchronous reset between edges, just after a write response.
    wr("wr9_pre_rst", 24'd9, 32'h99);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_success", {63'd0, o_success}, 64'd0);
    check("midrst_data", {32'd0, o_data}, 64'd0);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
`ifdef CACHE_RO_STATS_EN
    check("stats_hit_rst", {32'd0, o_hit_cnt}, 64'd0);
    check("stats_miss_rst", {32'd0, o_miss_cnt}, 64'd0);
    exp_hits = 0;
    exp_misses = 0;
`endif
    rd_miss("post_rst_rd4", 24'd4);
    rd_miss("post_rst_rd9", 24'd9);
    rd_miss("post_rst_rd32", 24'd32);
    wr("post_rst_wr4", 24'd4, 32'h44);
    rd_hit("post_rst_rd4_hit", 24'd4, 32'h44);
    idle("final_idle");

`ifdef CACHE_RO_STATS_EN
    check("stats_hits", {32'd0, o_hit_cnt}, 64'(exp_hits));
    check("stats_misses", {32'd0, o_miss_cnt}, 64'(exp_misses));
`endif

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
